ro_race_resp: RTL and testbench

Downstream consumer of the dual 4-bit ring-oscillator counters in the multi-bit CycROPUF. It detects wrap events (15->0) on count0 and count1 and races them over a window of WINDOW wraps; each race yields one response bit. N_BITS races are run per request, and the bits are shifted into a response register with a valid/busy handshake. The block runs entirely on clk0. count0 is native to clk0; count1 arrives from the clk1 domain and is synchronised here.

---
 rtl/ro_race_resp_if.sv | 24 ++
 rtl/ro_race_resp.sv | 123 ++++++++++++
 tb/tb_ro_race_resp.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ro_race_resp_if.sv
// Bundle of request/response and RO counter signals between the PUF counters,
// the requester and ro_race_resp.
`timescale 1ns/1ps
interface ro_race_resp_if #(
  parameter int N_BITS = 8
);
  logic              start;
  logic [3:0]        count0;
  logic [3:0]        count1;
  logic [N_BITS-1:0] resp;
  logic              resp_valid;
  logic              busy;
  logic              tie;

  modport master (
    output start, count0, count1,
    input  resp, resp_valid, busy, tie
  );

  modport slave (
    input  start, count0, count1,
    output resp, resp_valid, busy, tie
  );
endinterface

// File: rtl/ro_race_resp.sv
// Races RO0/RO1 counter wrap events over WINDOW wraps per bit and assembles
// N_BITS race outcomes into a response word with a valid/busy handshake.
`timescale 1ns/1ps
module ro_race_resp #(
  parameter int N_BITS = 8,
  parameter int WINDOW = 16,
  parameter int WCNT_W = 8
) (
  input logic             clk0,
  input logic             reset,
  ro_race_resp_if.slave   bus
);
  localparam int                IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [WCNT_W-1:0] WIN   = WCNT_W'(WINDOW);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_BITS - 1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t              state, state_next;
  logic [N_BITS-1:0]   resp, resp_next;
  logic                resp_valid, resp_valid_next;
  logic                tie, tie_next;
  logic [IDX_W-1:0]    bit_idx, bit_idx_next;
  logic                arm_cnt, arm_cnt_next;
  logic [WCNT_W-1:0]   w0, w0_next;
  logic [WCNT_W-1:0]   w1, w1_next;
  logic [WCNT_W-1:0]   n0, n1;
  logic                c1_s1, c1_s2, c1_p, c0_p;
  logic                wrap0, wrap1, hit0, hit1;
  logic                unused_cnt_bits;

  // Only the MSB of each counter matters: its falling edge marks a 15->0 wrap.
  assign unused_cnt_bits = &{bus.count0[2:0], bus.count1[2:0]};

  assign wrap0 = c0_p & ~bus.count0[3];
  assign wrap1 = c1_p & ~c1_s2;
  assign n0    = w0 + WCNT_W'(wrap0);
  assign n1    = w1 + WCNT_W'(wrap1);
  assign hit0  = (n0 == WIN);
  assign hit1  = (n1 == WIN);

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resp       <= '0;
      resp_valid <= 1'b0;
      tie        <= 1'b0;
      bit_idx    <= '0;
      arm_cnt    <= 1'b0;
      w0         <= '0;
      w1         <= '0;
      c1_s1      <= 1'b0;
      c1_s2      <= 1'b0;
      c1_p       <= 1'b0;
      c0_p       <= 1'b0;
    end else begin
      state      <= state_next;
      resp       <= resp_next;
      resp_valid <= resp_valid_next;
      tie        <= tie_next;
      bit_idx    <= bit_idx_next;
      arm_cnt    <= arm_cnt_next;
      w0         <= w0_next;
      w1         <= w1_next;
      c1_s1      <= bus.count1[3];
      c1_s2      <= c1_s1;
      c1_p       <= c1_s2;
      c0_p       <= bus.count0[3];
    end
  end

  always_comb begin
    state_next      = state;
    resp_next       = resp;
    resp_valid_next = resp_valid;
    tie_next        = tie;
    bit_idx_next    = bit_idx;
    arm_cnt_next    = arm_cnt;
    w0_next         = w0;
    w1_next         = w1;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next      = ARM;
          resp_next       = '0;
          resp_valid_next = 1'b0;
          tie_next        = 1'b0;
          bit_idx_next    = '0;
          arm_cnt_next    = 1'b0;
        end
      end
      ARM: begin
        // Two cycles with accumulators held at zero while the RO1 sync pipe flushes.
        w0_next      = '0;
        w1_next      = '0;
        arm_cnt_next = ~arm_cnt;
        if (arm_cnt) state_next = MEASURE;
      end
      MEASURE: begin
        w0_next = n0;
        w1_next = n1;
        if (hit0 || hit1) begin
          resp_next = {resp[N_BITS-2:0], hit1 & ~hit0};
          if (hit0 && hit1) tie_next = 1'b1;
          if (bit_idx == LAST) begin
            state_next      = DONE;
            resp_valid_next = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            arm_cnt_next = 1'b0;
            state_next   = ARM;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.resp       = resp;
  assign bus.resp_valid = resp_valid;
  assign bus.busy       = (state == ARM) || (state == MEASURE);
  assign bus.tie        = tie;
endmodule

// File: tb/tb_ro_race_resp.sv
// Directed bench for ro_race_resp: real RO counters on clk0/clk1, an event-level
// race model checked every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_ro_race_resp;
  localparam int NB  = 4;
  localparam int WIN = 4;

  logic       clk0 = 1'b0;
  logic       clk1 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] c0_cnt = 4'd0;
  logic [3:0] c1_cnt = 4'd0;
  logic [3:0] count1_drv;
  int         mode = 0;   // 0: RO1 dead, 1: clk1 counter, 2: copy of count0 advanced 2 cycles

  int n_cmp  = 0;
  int n_fail = 0;

  ro_race_resp_if #(.N_BITS(NB)) bus ();

  ro_race_resp #(.N_BITS(NB), .WINDOW(WIN), .WCNT_W(8)) dut (
    .clk0  (clk0),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk0 = ~clk0;
  initial begin
    #2 clk1 = 1'b1;
    forever #2.5 clk1 = ~clk1;
  end

  always @(posedge clk0) c0_cnt <= c0_cnt + 4'd1;
  always @(posedge clk1) c1_cnt <= c1_cnt + 4'd1;

  always_comb begin
    count1_drv = 4'd0;
    if (mode == 1) count1_drv = c1_cnt;
    else if (mode == 2) count1_drv = c0_cnt + 4'd2;
  end

  assign bus.start  = start;
  assign bus.count0 = c0_cnt;
  assign bus.count1 = count1_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Event-level model: wraps are MSB falling edges seen by clk0; RO1 events reach
  // the race 2 cycles later than RO0's because of synchronisation.
  logic [NB-1:0] m_resp  = '0;
  logic          m_valid = 1'b0;
  logic          m_tie   = 1'b0;
  logic          m_busy  = 1'b0;
  int            m_arm_left = 0;
  int            m_a0 = 0, m_a1 = 0, m_bits = 0;
  logic          hb0 = 1'b0;
  logic          h1_0 = 1'b0, h1_1 = 1'b0, h1_2 = 1'b0;
  int            model_prints = 0;

  initial forever begin
    @(negedge clk0);
    n_cmp++;
    if ({bus.resp, bus.resp_valid, bus.busy, bus.tie} !== {m_resp, m_valid, m_busy, m_tie}) begin
      n_fail++;
      if (model_prints < 20) begin
        model_prints++;
        $display("FAIL cycle @%0t: got resp=%b valid=%b busy=%b tie=%b, required resp=%b valid=%b busy=%b tie=%b",
                 $time, bus.resp, bus.resp_valid, bus.busy, bus.tie, m_resp, m_valid, m_busy, m_tie);
      end
    end
    #4;
    if (reset) begin
      m_resp = '0; m_valid = 0; m_tie = 0; m_busy = 0;
      m_arm_left = 0; m_a0 = 0; m_a1 = 0; m_bits = 0;
      hb0 = 0; h1_0 = 0; h1_1 = 0; h1_2 = 0;
    end else begin
      logic b0, b1, ev0, ev1, bitv;
      b0  = c0_cnt[3];
      b1  = count1_drv[3];
      ev0 = hb0 & ~b0;
      ev1 = h1_2 & ~h1_1;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_arm_left = 2; m_resp = '0; m_valid = 0; m_tie = 0; m_bits = 0;
        end
      end else if (m_arm_left > 0) begin
        m_arm_left--; m_a0 = 0; m_a1 = 0;
      end else begin
        m_a0 += int'(ev0);
        m_a1 += int'(ev1);
        if (m_a0 == WIN || m_a1 == WIN) begin
          bitv = (m_a1 == WIN) && (m_a0 != WIN);
          if (m_a0 == WIN && m_a1 == WIN) m_tie = 1;
          m_resp = {m_resp[NB-2:0], bitv};
          m_bits++;
          if (m_bits == NB) begin
            m_busy = 0; m_valid = 1;
          end else begin
            m_arm_left = 2;
          end
        end
      end
      hb0 = b0; h1_2 = h1_1; h1_1 = h1_0; h1_0 = b1;
    end
  end

  task automatic do_start();
    @(negedge clk0); #1 start = 1'b1;
    @(negedge clk0); #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string name, output int cycles);
    cycles = 1;
    while (!bus.resp_valid && cycles < budget) begin
      @(negedge clk0);
      cycles++;
    end
    check({name, "_valid_in_time"}, {31'd0, bus.resp_valid}, 32'd1);
    $display("%s: resp=%b tie=%b cycles=%0d", name, bus.resp, bus.tie, cycles);
  endtask

  int cyc;

  initial begin
    repeat (2) @(negedge clk0);
    #1;
    check("reset_outputs", {28'd0, bus.resp, bus.resp_valid, bus.busy, bus.tie}, 32'd0);
    #1 reset = 1'b0;

    // RO1 dead: every race lost by RO1.
    mode = 0;
    do_start();
    wait_valid(270, "dead_ro1", cyc);
    check("dead_resp", {28'd0, bus.resp}, 32'h0);
    check("dead_tie", {31'd0, bus.tie}, 32'd0);

    // RO1 twice as fast: every race won by RO1; busy falls with valid rising.
    @(negedge clk0); #1 mode = 1;
    do_start();
    wait_valid(270, "fast_ro1", cyc);
    check("fast_resp", {28'd0, bus.resp}, 32'hF);
    check("fast_busy_at_valid", {31'd0, bus.busy}, 32'd0);
    check("fast_tie", {31'd0, bus.tie}, 32'd0);

    // Restart from DONE clears the response immediately.
    do_start();
    check("restart_clear", {28'd0, bus.resp, bus.resp_valid, bus.busy}, {26'd0, 4'b0000, 1'b0, 1'b1});
    wait_valid(270, "restart", cyc);
    check("restart_resp", {28'd0, bus.resp}, 32'hF);

    // start pulses in ARM and mid-MEASURE are ignored.
    do_start();
    start = 1'b1;
    @(negedge clk0); #1 start = 1'b0;
    repeat (8) @(negedge clk0);
    #1 start = 1'b1;
    check("busy_mid_measure", {31'd0, bus.busy}, 32'd1);
    @(negedge clk0); #1 start = 1'b0;
    wait_valid(270, "ignore_start", cyc);
    check("ignore_resp", {28'd0, bus.resp}, 32'hF);

    // Coincident wraps: every race ties.
    @(negedge clk0); #1 mode = 2;
    do_start();
    wait_valid(270, "tie", cyc);
    check("tie_resp", {28'd0, bus.resp}, 32'h0);
    check("tie_flag", {31'd0, bus.tie}, 32'd1);

    // Reset mid-MEASURE acts immediately.
    @(negedge clk0); #1 mode = 1;
    do_start();
    repeat (10) @(negedge clk0);
    #2 reset = 1'b1;
    #1 check("reset_mid_race", {28'd0, bus.resp, bus.resp_valid, bus.busy, bus.tie}, 32'd0);
    repeat (2) @(negedge clk0);
    #2 reset = 1'b0;
    do_start();
    wait_valid(270, "after_reset", cyc);
    check("after_reset_resp", {28'd0, bus.resp}, 32'hF);

    repeat (3) @(negedge clk0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
